chunked_compare_unit: RTL and testbench

//  Multi-cycle magnitude comparator for the ALU set-less-than path.
//  - Generalises the single-mode unsigned less-than block: parametrised width, signed/unsigned
//    per operation, full lt/eq/gt flags.
//  - Compares CHUNK bits per cycle, MSB chunk first, behind valid/ready handshakes on both sides.
//  - Sits between the decode-stage operand latch and the writeback mux.

---
 rtl/chunked_compare_unit.sv | 160 ++++++++++++++++
 tb/tb_chunked_compare_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_compare_unit.sv
// chunked_compare_unit
//   Multi-cycle magnitude comparator for the ALU set-less-than path.
//   Compares CHUNK bits per cycle, most significant chunk first, and
//   reports one-hot lt/eq/gt plus the SLT word {WIDTH-1 zeros, lt}.
//   Signed operands are biased (MSB inverted) at capture so that one
//   unsigned chunk compare serves both modes.
//
// Configuration macro: CMP_EARLY_EXIT_EN
//   defined   : leave CMP on the first differing chunk (variable latency)
//   undefined : always spend NCHUNK cycles in CMP (fixed latency)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands/mode presented
//   in_ready   unit can accept (IDLE and not in reset)
//   a, b       operands, WIDTH bits
//   is_signed  1: two's-complement compare, 0: unsigned
//   out_valid  result registers valid
//   out_ready  consumer takes result
//   out        SLT word {WIDTH-1 zeros, lt}
//   lt,eq,gt   one-hot compare flags while out_valid=1
module chunked_compare_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] SIGN_BIAS = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [IDXW-1:0]   idx;
    logic [CHUNK-1:0]  ca;
    logic [CHUNK-1:0]  cb;
    logic              chunk_lt;
    logic              chunk_diff;
    logic              last;
    logic              finish;
    logic              res_lt;
    logic              res_gt;
    logic              res_eq;
`ifndef CMP_EARLY_EXIT_EN
    // First differing chunk seen so far; later chunks must not override it.
    logic              found;
    logic              rec_lt;
`endif

    assign in_ready = (state == IDLE) && !rst;

    // Select chunk idx, counted from the most significant end.
    always_comb begin
        ca = '0;
        cb = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) begin
                ca = a_r[(NCHUNK-1-i)*CHUNK +: CHUNK];
                cb = b_r[(NCHUNK-1-i)*CHUNK +: CHUNK];
            end
        end
    end

    always_comb begin
        chunk_lt   = (ca < cb);
        chunk_diff = (ca != cb);
        last       = (idx == IDXW'(NCHUNK - 1));
`ifdef CMP_EARLY_EXIT_EN
        finish = chunk_diff || last;
        res_lt = chunk_diff && chunk_lt;
        res_gt = chunk_diff && !chunk_lt;
        res_eq = !chunk_diff;
`else
        finish = last;
        res_lt = found ? rec_lt  : (chunk_diff && chunk_lt);
        res_gt = found ? !rec_lt : (chunk_diff && !chunk_lt);
        res_eq = !found && !chunk_diff;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
            found     <= 1'b0;
            rec_lt    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= is_signed ? (a ^ SIGN_BIAS) : a;
                        b_r   <= is_signed ? (b ^ SIGN_BIAS) : b;
                        idx   <= '0;
`ifndef CMP_EARLY_EXIT_EN
                        found  <= 1'b0;
                        rec_lt <= 1'b0;
`endif
                        state <= CMP;
                    end
                end
                CMP: begin
`ifndef CMP_EARLY_EXIT_EN
                    if (!found && chunk_diff) begin
                        found  <= 1'b1;
                        rec_lt <= chunk_lt;
                    end
`endif
                    if (finish) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        lt        <= res_lt;
                        eq        <= res_eq;
                        gt        <= res_gt;
                        out       <= WIDTH'(res_lt);
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out       <= '0;
                        lt        <= 1'b0;
                        eq        <= 1'b0;
                        gt        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_compare_unit.sv
module tb_chunked_compare_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit / 8-bit chunk instance
    logic        in_valid, in_ready, is_signed, out_valid, out_ready, lt, eq, gt;
    logic [31:0] a, b, out;

    // 16-bit / 4-bit chunk instance
    logic        in_valid_h, in_ready_h, is_signed_h, out_valid_h, out_ready_h, lt_h, eq_h, gt_h;
    logic [15:0] a_h, b_h, out_h;

    int checks = 0;
    int errors = 0;
    int lat;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    chunked_compare_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .lt(lt), .eq(eq), .gt(gt)
    );

    chunked_compare_unit #(.WIDTH(16), .CHUNK(4)) dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid_h), .in_ready(in_ready_h),
        .a(a_h), .b(b_h), .is_signed(is_signed_h), .out_valid(out_valid_h),
        .out_ready(out_ready_h), .out(out_h), .lt(lt_h), .eq(eq_h), .gt(gt_h)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected latency: first differing chunk from the MSB end (bias flips the
    // same bit in both operands, so raw operands give the same answer).
    function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y,
                                   input int n, input int c);
        logic [31:0] mask;
        mask = (32'd1 << c) - 32'd1;
        for (int j = 0; j < n; j++) begin
            if (((x >> ((n-1-j)*c)) & mask) != ((y >> ((n-1-j)*c)) & mask))
                return EARLY ? j + 1 : n;
        end
        return n;
    endfunction

    task automatic op32(input logic [31:0] av, input logic [31:0] bv,
                        input logic sg, input logic rdy, output int l);
        out_ready = rdy;
        a = av; b = bv; is_signed = sg; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = ~av; b = ~bv; is_signed = ~sg;
        l = 0;
        while (!out_valid && l < 40) begin
            step();
            l++;
        end
    endtask

    task automatic op16(input logic [15:0] av, input logic [15:0] bv,
                        input logic sg, output int l);
        out_ready_h = 1'b1;
        a_h = av; b_h = bv; is_signed_h = sg; in_valid_h = 1'b1;
        step();
        in_valid_h = 1'b0;
        a_h = ~av; b_h = ~bv;
        l = 0;
        while (!out_valid_h && l < 40) begin
            step();
            l++;
        end
    endtask

    task automatic drained32(input string tag);
        step();
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_flags_clr"}, {lt, eq, gt}, 3'b000);
        check({tag, "_out_clr"}, out, 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        logic        mlt, meq, mgt;

        rst = 1'b1;
        in_valid = 0; a = '0; b = '0; is_signed = 0; out_ready = 0;
        in_valid_h = 0; a_h = '0; b_h = '0; is_signed_h = 0; out_ready_h = 1;
        step(); step(); step();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_flags", {lt, eq, gt}, 3'b000);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid_h", out_valid_h, 0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_in_ready_h", in_ready_h, 1);

        // 1: 1 < 2 unsigned, difference in the last chunk
        op32(32'd1, 32'd2, 1'b0, 1'b1, lat);
        check("t1_lat", lat, 4);
        check("t1_flags", {lt, eq, gt}, 3'b100);
        check("t1_out", out, 32'h1);
        drained32("t1");

        // 2: 0x8000_0000 vs 1
        op32(32'h8000_0000, 32'd1, 1'b0, 1'b1, lat);
        check("t2u_lat", lat, EARLY ? 1 : 4);
        check("t2u_flags", {lt, eq, gt}, 3'b001);
        check("t2u_out", out, 32'h0);
        drained32("t2u");
        op32(32'h8000_0000, 32'd1, 1'b1, 1'b1, lat);
        check("t2s_lat", lat, EARLY ? 1 : 4);
        check("t2s_flags", {lt, eq, gt}, 3'b100);
        check("t2s_out", out, 32'h1);
        drained32("t2s");

        // 3: equal operands, signed
        op32(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1, lat);
        check("t3_lat", lat, 4);
        check("t3_flags", {lt, eq, gt}, 3'b010);
        check("t3_out", out, 32'h0);
        drained32("t3");

        // 4: backpressure, competing in_valid ignored
        op32(32'd1, 32'd2, 1'b0, 1'b0, lat);
        check("t4_lat", lat, 4);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 32'd7; b = 32'd3; is_signed = 1'b0;
            step();
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_flags", {lt, eq, gt}, 3'b100);
            check("t4_hold_out", out, 32'h1);
            check("t4_hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drained32("t4");
        step();
        check("t4_no_ghost_op", out_valid, 0);

        // 5: reset on the 2nd CMP cycle abandons the operation
        a = 32'd5; b = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("t5_out_valid", out_valid, 0);
        check("t5_flags", {lt, eq, gt}, 3'b000);
        check("t5_out", out, 0);
        check("t5_in_ready_rst", in_ready, 0);
        rst = 1'b0;
        #1;
        check("t5_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_no_result", out_valid, 0);
        end
        op32(32'd3, 32'd5, 1'b0, 1'b1, lat);
        check("t5_lat", lat, 4);
        check("t5_flags_next", {lt, eq, gt}, 3'b100);
        drained32("t5");

        // 6: WIDTH=16, CHUNK=4
        op16(16'hFFFF, 16'h7FFF, 1'b1, lat);
        check("t6s_lat", lat, EARLY ? 1 : 4);
        check("t6s_flags", {lt_h, eq_h, gt_h}, 3'b100);
        check("t6s_out", out_h, 16'h1);
        step();
        check("t6s_drop", out_valid_h, 0);
        op16(16'hFFFF, 16'h7FFF, 1'b0, lat);
        check("t6u_lat", lat, EARLY ? 1 : 4);
        check("t6u_flags", {lt_h, eq_h, gt_h}, 3'b001);
        check("t6u_out", out_h, 16'h0);
        step();
        check("t6u_drop", out_valid_h, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            // Bias toward shared upper chunks so later chunks get exercised.
            if (i % 4 == 1) rb = {ra[15:4], rb[3:0]};
            if (i % 4 == 2) rb = {ra[15:8], rb[7:0]};
            if (i % 8 == 3) rb = ra;
            rs = 1'($urandom);
            if (rs) begin
                mlt = $signed(ra) < $signed(rb);
                mgt = $signed(ra) > $signed(rb);
            end else begin
                mlt = $unsigned(ra) < $unsigned(rb);
                mgt = $unsigned(ra) > $unsigned(rb);
            end
            meq = (ra == rb);
            op16(ra, rb, rs, lat);
            check("rnd_lat", lat, exp_lat({16'h0, ra}, {16'h0, rb}, 4, 4));
            check("rnd_flags", {lt_h, eq_h, gt_h}, {mlt, meq, mgt});
            check("rnd_out", out_h, {15'h0, mlt});
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
